rv32_multicycle_ctrl: RTL

Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared single-ALU datapath. Drives the immediate generator's 3-bit format select and all datapath enables and muxes. Runs request/ready handshakes to instruction and data memory and counts retired instructions.

---
 rtl/rv32_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing,
// immediate format select, memory handshakes and retired-instruction count.
module rv32_multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 br_taken,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic [2:0]           ext_op,
  output logic                 alu_a_pc,
  output logic                 alu_b_imm,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_e;

  typedef enum logic [3:0] {
    K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR,
    K_OPIMM, K_OP, K_LUI, K_AUIPC, K_ILL
  } kind_e;

  state_e                 state_q, state_d;
  kind_e                  kind_q, kind_d, dec_kind;
  logic [2:0]             ext_op_q, ext_op_d, dec_ext;
  logic                   trap_q, trap_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic [2:0]             funct3;
  logic                   rd_nz;
  logic                   unused_inst;

  assign funct3      = inst[14:12];
  assign rd_nz       = |inst[11:7];
  assign unused_inst = ^inst[31:15];

  // Opcode and funct3 legality decode of the instruction register
  always_comb begin
    dec_kind = K_ILL;
    dec_ext  = 3'b000;
    case (inst[6:0])
      OPC_LOAD: begin
        if (!(funct3 inside {3'b011, 3'b110, 3'b111})) dec_kind = K_LOAD;
      end
      OPC_STORE: begin
        dec_ext = 3'b011;
        if (funct3 <= 3'b010) dec_kind = K_STORE;
      end
      OPC_BRANCH: begin
        dec_ext = 3'b001;
        if (!(funct3 inside {3'b010, 3'b011})) dec_kind = K_BRANCH;
      end
      OPC_JAL: begin
        dec_ext  = 3'b010;
        dec_kind = K_JAL;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) dec_kind = K_JALR;
      end
      OPC_OPIMM: dec_kind = K_OPIMM;
      OPC_OP:    dec_kind = K_OP;
      OPC_LUI: begin
        dec_ext  = 3'b100;
        dec_kind = K_LUI;
      end
      OPC_AUIPC: begin
        dec_ext  = 3'b100;
        dec_kind = K_AUIPC;
      end
      default: dec_kind = K_ILL;
    endcase
  end

  // Strobes depend on same-cycle ready/branch inputs, so decode from state
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        EXEC: begin
          alu_a_pc  = kind_q inside {K_AUIPC, K_JAL, K_BRANCH};
          alu_b_imm = !(kind_q inside {K_OP, K_BRANCH});
          if (kind_q == K_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = {1'b0, br_taken};
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (kind_q == K_STORE);
          pc_we    = dmem_ready && (kind_q == K_STORE);
        end
        WB: begin
          rf_we = rd_nz;
          pc_we = 1'b1;
          case (kind_q)
            K_LOAD:        wb_sel = 2'b01;
            K_JAL, K_JALR: wb_sel = 2'b10;
            K_LUI:         wb_sel = 2'b11;
            default:       wb_sel = 2'b00;
          endcase
          case (kind_q)
            K_JAL:   pc_sel = 2'b01;
            K_JALR:  pc_sel = 2'b10;
            default: pc_sel = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    ext_op_d  = ext_op_q;
    trap_d    = trap_q;
    instret_d = instret_q + INSTRET_W'(pc_we);
    case (state_q)
      FETCH: begin
        if (imem_ready) state_d = DECODE;
      end
      DECODE: begin
        kind_d = dec_kind;
        if (dec_kind == K_ILL) begin
          state_d = TRAP;
          trap_d  = 1'b1;
        end else begin
          ext_op_d = dec_ext;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        case (kind_q)
          K_BRANCH:       state_d = FETCH;
          K_LOAD, K_STORE: state_d = MEM;
          default:        state_d = WB;
        endcase
      end
      MEM: begin
        if (dmem_ready) state_d = (kind_q == K_STORE) ? FETCH : WB;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      kind_q    <= K_OP;
      ext_op_q  <= 3'b000;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      ext_op_q  <= ext_op_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  assign ext_op  = ext_op_q;
  assign trap    = trap_q;
  assign instret = instret_q;

endmodule
